// File: rtl/mux_arbiter4.sv
// Round-robin arbiter for four requesters sharing one 4:1 mux, with a per-grant
// hold limit and a one-cycle turnaround between owners.
//
// state | meaning
// IDLE  | no owner; arbitrate on the next edge if any request is up
// GRANT | owner holds the mux; hcnt counts cycles held
// TURN  | one dead cycle after release before arbitrating again
module mux_arbiter4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state, state_nx;
  logic [1:0] ptr, ptr_nx;
  logic [1:0] owner, owner_nx;
  logic [1:0] sel_q, sel_nx;
  logic [7:0] hcnt, hcnt_nx;

  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;

  // Scan from the farthest offset down so the bit closest to ptr wins.
  always_comb begin
    pick  = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      owner <= 2'd0;
      sel_q <= 2'd0;
      hcnt  <= 8'd0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
      sel_q <= sel_nx;
      hcnt  <= hcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    sel_nx   = sel_q;
    hcnt_nx  = hcnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          owner_nx = pick;
          sel_nx   = pick;
          hcnt_nx  = 8'd1;
        end
      end
      GRANT: begin
        if (!req[owner] || hcnt == HOLD_LIM) begin
          state_nx = TURN;
          ptr_nx   = owner + 2'd1;
        end else if (hcnt < HOLD_LIM) begin
          hcnt_nx = hcnt + 8'd1;
        end
      end
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode only registered state, so reset clears them at once.
  always_comb begin
    gnt  = 4'b0000;
    busy = 1'b0;
    sel  = sel_q;
    if (state == GRANT) begin
      gnt[owner] = 1'b1;
      busy       = 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_arbiter4.sv
// Bench for mux_arbiter4: three instances (hold limits 16, 4, 1) checked against
// a cycle-level reference model, fixed vector table and hand-written sequences.
module tb_mux_arbiter4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_a  [3];
  logic [3:0] gnt_a  [3];
  logic [1:0] sel_a  [3];
  logic       busy_a [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_arbiter4 #(.MAX_HOLD(16)) u0 (.clk(clk), .reset(reset), .req(req_a[0]),
    .gnt(gnt_a[0]), .sel(sel_a[0]), .busy(busy_a[0]));
  mux_arbiter4 #(.MAX_HOLD(4))  u1 (.clk(clk), .reset(reset), .req(req_a[1]),
    .gnt(gnt_a[1]), .sel(sel_a[1]), .busy(busy_a[1]));
  mux_arbiter4 #(.MAX_HOLD(1))  u2 (.clk(clk), .reset(reset), .req(req_a[2]),
    .gnt(gnt_a[2]), .sel(sel_a[2]), .busy(busy_a[2]));

  // Reference model: phase 0 = free, 1 = owned, 2 = turnaround cycle.
  int lim     [3] = '{16, 4, 1};
  int m_phase [3];
  int m_ptr   [3];
  int m_owner [3];
  int m_held  [3];
  int m_sel   [3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_phase[i] = 0; m_ptr[i] = 0; m_owner[i] = 0; m_held[i] = 0; m_sel[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input logic [3:0] r);
    case (m_phase[i])
      0: if (r != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (m_phase[i] == 0 && r[(m_ptr[i] + k) % 4]) begin
            m_owner[i] = (m_ptr[i] + k) % 4;
            m_sel[i]   = m_owner[i];
            m_held[i]  = 1;
            m_phase[i] = 1;
          end
        end
      end
      1: if (!r[m_owner[i]] || m_held[i] >= lim[i]) begin
        m_phase[i] = 2;
        m_ptr[i]   = (m_owner[i] + 1) % 4;
      end else begin
        m_held[i] = m_held[i] + 1;
      end
      default: m_phase[i] = 0;
    endcase
  endtask

  function automatic int exp_gnt(input int i);
    return (m_phase[i] == 1) ? (1 << m_owner[i]) : 0;
  endfunction

  task automatic check_model(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s u%0d gnt", tag, i), gnt_a[i], exp_gnt(i));
      chk($sformatf("%s u%0d sel", tag, i), sel_a[i], m_sel[i]);
      chk($sformatf("%s u%0d busy", tag, i), busy_a[i], (m_phase[i] == 1) ? 1 : 0);
      chk($sformatf("%s u%0d onehot", tag, i), ($countones(gnt_a[i]) <= 1) ? 1 : 0, 1);
      chk($sformatf("%s u%0d gnt_vs_busy", tag, i), (gnt_a[i] != 4'b0000) ? 1 : 0,
          busy_a[i] ? 1 : 0);
    end
  endtask

  task automatic step(input string tag);
    logic [3:0] r [3];
    for (int i = 0; i < 3; i++) r[i] = req_a[i];
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i, r[i]);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) req_a[i] = 4'b0000;
    model_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset u%0d gnt", i), gnt_a[i], 0);
      chk($sformatf("reset u%0d sel", i), sel_a[i], 0);
      chk($sformatf("reset u%0d busy", i), busy_a[i], 0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t tbl [12];

  initial begin
    for (int i = 0; i < 3; i++) req_a[i] = 4'b0000;
    model_reset();

    tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[4]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[6]  = '{4'b1010, 4'b1000, 2'd3, 1'b1};
    tbl[7]  = '{4'b0010, 4'b0000, 2'd3, 1'b0};
    tbl[8]  = '{4'b0010, 4'b0000, 2'd3, 1'b0};
    tbl[9]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[10] = '{4'b0000, 4'b0000, 2'd1, 1'b0};
    tbl[11] = '{4'b0000, 4'b0000, 2'd1, 1'b0};

    do_reset();
    for (int v = 0; v < 12; v++) begin
      req_a[0] = tbl[v].req;
      step("table");
      chk($sformatf("tbl%0d gnt", v), gnt_a[0], tbl[v].gnt);
      chk($sformatf("tbl%0d sel", v), sel_a[0], tbl[v].sel);
      chk($sformatf("tbl%0d busy", v), busy_a[0], tbl[v].busy);
    end

    // Owner 2 drops while req[1] rises: dead cycles, then requester 1 wins.
    do_reset();
    req_a[0] = 4'b0100; step("handoff");
    chk("handoff grant2", gnt_a[0], 4'b0100);
    req_a[0] = 4'b0010; step("handoff");
    chk("handoff release", gnt_a[0], 4'b0000);
    step("handoff");
    chk("handoff turn", gnt_a[0], 4'b0000);
    step("handoff");
    chk("handoff grant1", gnt_a[0], 4'b0010);
    chk("handoff sel1", sel_a[0], 1);

    // Hold limit 4 with all requesting; hold limit 1 with two requesting.
    do_reset();
    req_a[1] = 4'b1111;
    req_a[2] = 4'b0011;
    for (int c = 0; c < 30; c++) begin
      step("rotate");
      chk($sformatf("hold4 c%0d", c), gnt_a[1],
          ((c % 6) < 4) ? (1 << ((c / 6) % 4)) : 0);
      chk($sformatf("hold1 c%0d", c), gnt_a[2],
          ((c % 3) == 0) ? (1 << ((c / 3) % 2)) : 0);
    end

    // Reset pulsed mid-cycle during a grant.
    do_reset();
    req_a[0] = 4'b0001;
    step("midrst");
    step("midrst");
    chk("midrst before", gnt_a[0], 4'b0001);
    #3 reset = 1'b1;
    #1;
    chk("midrst gnt", gnt_a[0], 0);
    chk("midrst sel", sel_a[0], 0);
    chk("midrst busy", busy_a[0], 0);
    model_reset();
    #1 reset = 1'b0;
    step("midrst");
    chk("midrst regrant", gnt_a[0], 4'b0001);

    // Randomized traffic, different churn per instance.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) req_a[0] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0)  req_a[1] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0)  req_a[2] = 4'($urandom_range(0, 15));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
